trig_debounce: RTL and testbench
================================

Name: trig_debounce

Overview:
Front-end conditioner for the binary counter stage. It turns a raw, bouncing, asynchronous push-button level into clean single-cycle `trig` pulses for that stage's `trig` input. It synchronises and debounces the input, emits one pulse per accepted press, and optionally emits auto-repeat pulses while the button is held. It sits between the board pin and the counter, in the same clock domain as the counter.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a press or a release; must be >= 1.
- REPEAT_EN, 1: 1 enables auto-repeat pulses while held; 0 gives exactly one pulse per press.
- REPEAT_DELAY, 50000000: cycles from the initial pulse to the first repeat pulse; must be >= 1.
- REPEAT_RATE, 10000000: cycles between subsequent repeat pulses; must be >= 1.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- n_rst, input, 1: asynchronous active-low reset.
- btn_in, input, 1: raw button level, asynchronous to clk, active-high.
- trig, output, 1: registered one-cycle pulse per accepted press or repeat; drives the counter's `trig`.
- trig_rpt, output, 1: registered; high together with `trig` only when the pulse is an auto-repeat.
- pressed, output, 1: registered debounced button level.

Behaviour:
- Reset, asynchronous, active-low, clock `clk` / reset `n_rst`:
  - all flops clear immediately: synchroniser = 0, state = IDLE, counters = 0.
  - trig = 0, trig_rpt = 0, pressed = 0.
  - Reset mid-press or mid-repeat aborts with no pulse. After release of reset the FSM restarts from IDLE; a button still held is re-debounced and produces a fresh initial pulse.
- Synchroniser: 2-flop chain, btn_in -> s1 -> btn_s. The FSM sees only btn_s, which lags btn_in by 2 edges.
- Debounce counter dcnt: width = $clog2(DEBOUNCE_CYCLES) with a minimum of 1. Repeat counter rcnt: width sized for max(REPEAT_DELAY, REPEAT_RATE). A `rlim` flag selects DELAY or RATE as the current repeat limit.
- FSM states IDLE, PRESS_CHK, HELD, REL_CHK. Every edge below is a rising clk edge.
  - IDLE: btn_s = 1 -> PRESS_CHK, dcnt <= 0.
  - PRESS_CHK:
    - btn_s = 0 -> IDLE (bounce rejected, no pulse).
    - btn_s = 1 and dcnt = DEBOUNCE_CYCLES-1 -> HELD, trig <= 1, rcnt <= 0, rlim <= DELAY.
    - otherwise dcnt++.
  - HELD:
    - btn_s = 0 -> REL_CHK, dcnt <= 0.
    - else, if REPEAT_EN and rcnt = limit-1: trig <= 1, trig_rpt <= 1, rcnt <= 0, rlim <= RATE.
    - else rcnt++ (saturates when REPEAT_EN = 0).
  - REL_CHK:
    - btn_s = 1 -> HELD with rcnt <= 0, rlim <= DELAY, no pulse. A release bounce restarts repeat timing from DELAY.
    - btn_s = 0 and dcnt = DEBOUNCE_CYCLES-1 -> IDLE.
    - otherwise dcnt++.
- trig and trig_rpt default to 0 every cycle, so each pulse is exactly 1 cycle wide and there are never back-to-back initial pulses.
- pressed = 1 exactly while state is HELD or REL_CHK, registered alongside the state.
- Latency: if btn_in is first sampled high at edge k and stays high, trig is high from edge k+2+DEBOUNCE_CYCLES to the following edge.
- Repeat timing: with the initial pulse at edge e, repeat pulses occur at e+REPEAT_DELAY, then every REPEAT_RATE edges, until btn_s drops.
- No pulse is ever generated on release.
- No pulse is generated in PRESS_CHK or REL_CHK.
- Parameter legality is checked at elaboration (simulation $error if any limit is < 1).

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
1. Reset: hold n_rst=0 for 10 ns with btn_in=1, then release -> trig, trig_rpt, pressed are 0 during reset. After release, trig pulses once at edge 6 after the first sampling edge.
2. Clean press, REPEAT_EN=0: btn_in high for 40 cycles, then low -> exactly 1 trig pulse, 1 cycle wide. pressed rises with trig and falls 6 edges after btn_in falls. trig_rpt stays 0.
3. Bounce reject: btn_in toggles 1,1,0,1,0 (1 cycle each), then stays low -> no trig, pressed stays 0, FSM returns to IDLE.
4. Auto-repeat, REPEAT_EN=1: hold btn_in for 40 cycles after the initial pulse at edge e -> trig at e, e+20, e+25, e+30, e+35. trig_rpt is high on all but the first.
5. Release bounce: while HELD, drop btn_in for 2 cycles, then raise it again -> no pulse, pressed stays 1. The next repeat occurs 20 edges after re-entering HELD.
6. Mid-operation reset: assert n_rst=0 one cycle before a scheduled repeat pulse -> outputs clear asynchronously and the pulse is never emitted.

Source files
------------

// File: rtl/trig_debounce.sv
// Push-button conditioner: 2-flop synchroniser, press/release debounce and
// optional auto-repeat, producing single-cycle trig pulses for the counter stage.
module trig_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic btn_in,
  output logic trig,
  output logic trig_rpt,
  output logic pressed
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic          RLIM_DELAY = 1'b0;
  localparam logic          RLIM_RATE  = 1'b1;

  if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
    $error("trig_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_chk_delay
    $error("trig_debounce: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_RATE < 1) begin : g_chk_rate
    $error("trig_debounce: REPEAT_RATE must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  logic          s1_q;
  logic          btn_s_q;
  state_t        state_q;
  logic [DW-1:0] dcnt_q;
  logic [RW-1:0] rcnt_q;
  logic          rlim_q;
  logic          trig_q;
  logic          trig_rpt_q;
  logic          pressed_q;

  logic [DW-1:0] dcnt_d;
  logic [RW-1:0] rcnt_d;
  logic [RW-1:0] rcnt_last;
  logic          dcnt_done;
  logic          rcnt_done;

  assign dcnt_d    = dcnt_q + 1'b1;
  assign dcnt_done = (dcnt_q == DCNT_LAST);
  assign rcnt_last = (rlim_q == RLIM_RATE) ? RATE_LAST : DELAY_LAST;
  assign rcnt_done = (REPEAT_EN != 0) && (rcnt_q == rcnt_last);

  // Without repeat the hold timer is meaningless; park it at all-ones instead of wrapping.
  assign rcnt_d = ((REPEAT_EN == 0) && (rcnt_q == '1)) ? rcnt_q : rcnt_q + 1'b1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_q       <= 1'b0;
      btn_s_q    <= 1'b0;
      state_q    <= IDLE;
      dcnt_q     <= '0;
      rcnt_q     <= '0;
      rlim_q     <= RLIM_DELAY;
      trig_q     <= 1'b0;
      trig_rpt_q <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      s1_q       <= btn_in;
      btn_s_q    <= s1_q;
      trig_q     <= 1'b0;
      trig_rpt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s_q) begin
            state_q <= PRESS_CHK;
            dcnt_q  <= '0;
          end
        end
        PRESS_CHK: begin
          if (!btn_s_q) begin
            state_q <= IDLE;
          end else if (dcnt_done) begin
            state_q   <= HELD;
            pressed_q <= 1'b1;
            trig_q    <= 1'b1;
            rcnt_q    <= '0;
            rlim_q    <= RLIM_DELAY;
          end else begin
            dcnt_q <= dcnt_d;
          end
        end
        HELD: begin
          if (!btn_s_q) begin
            state_q <= REL_CHK;
            dcnt_q  <= '0;
          end else if (rcnt_done) begin
            trig_q     <= 1'b1;
            trig_rpt_q <= 1'b1;
            rcnt_q     <= '0;
            rlim_q     <= RLIM_RATE;
          end else begin
            rcnt_q <= rcnt_d;
          end
        end
        REL_CHK: begin
          // A bounce back to pressed restarts the long initial repeat delay.
          if (btn_s_q) begin
            state_q <= HELD;
            rcnt_q  <= '0;
            rlim_q  <= RLIM_DELAY;
          end else if (dcnt_done) begin
            state_q   <= IDLE;
            pressed_q <= 1'b0;
          end else begin
            dcnt_q <= dcnt_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign trig     = trig_q;
  assign trig_rpt = trig_rpt_q;
  assign pressed  = pressed_q;

endmodule

// File: tb/tb_trig_debounce.sv
// Bench for trig_debounce: a repeat and a no-repeat instance share one button
// stimulus and are checked every cycle against a run-length/timer model.
module tb_trig_debounce;

  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int RT  = 5;

  logic clk;
  logic n_rst;
  logic btn_in;
  logic trig_r, rpt_r, prs_r;
  logic trig_n, rpt_n, prs_n;

  int total;
  int bad;
  int ecnt;

  // Model state: index 0 = repeat instance, 1 = no-repeat instance
  bit a1, a2;
  bit m_prs [2];
  int m_run [2];
  int m_t   [2];
  int m_ivl [2];
  bit e_trig[2];
  bit e_rpt [2];

  int rep_q[$];
  int rep_rq[$];
  int nor_q[$];
  int nor_fall[$];
  bit prev_prs_n;

  trig_debounce #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_RATE(RT)
  ) u_rep (
    .clk(clk), .n_rst(n_rst), .btn_in(btn_in),
    .trig(trig_r), .trig_rpt(rpt_r), .pressed(prs_r)
  );

  trig_debounce #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(DLY), .REPEAT_RATE(RT)
  ) u_norep (
    .clk(clk), .n_rst(n_rst), .btn_in(btn_in),
    .trig(trig_n), .trig_rpt(rpt_n), .pressed(prs_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic model_reset();
    a1 = 1'b0;
    a2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_prs[i] = 1'b0; m_run[i] = 0; m_t[i] = 0; m_ivl[i] = DLY;
      e_trig[i] = 1'b0; e_rpt[i] = 1'b0;
    end
  endtask

  // A press/release is accepted after DB+1 consecutive synchronised samples
  // at the new level; repeats fire DLY then every RT edges after the last
  // (re)start of the hold timer.
  task automatic model_edge(input bit b);
    bit lvl;
    lvl = a2;
    a2  = a1;
    a1  = b;
    for (int i = 0; i < 2; i++) begin
      e_trig[i] = 1'b0;
      e_rpt[i]  = 1'b0;
      if (!m_prs[i]) begin
        if (lvl) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_prs[i] = 1'b1; m_run[i] = 0; e_trig[i] = 1'b1;
            m_t[i] = 0; m_ivl[i] = DLY;
          end
        end else begin
          m_run[i] = 0;
        end
      end else begin
        if (!lvl) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_prs[i] = 1'b0; m_run[i] = 0;
          end
        end else if (m_run[i] > 0) begin
          m_run[i] = 0; m_t[i] = 0; m_ivl[i] = DLY;
        end else begin
          m_t[i]++;
          if (i == 0 && m_t[i] == m_ivl[i]) begin
            e_trig[i] = 1'b1; e_rpt[i] = 1'b1; m_t[i] = 0; m_ivl[i] = RT;
          end
        end
      end
    end
  endtask

  task automatic compare_cycle();
    chk("rep.trig",      int'(trig_r), int'(e_trig[0]));
    chk("rep.trig_rpt",  int'(rpt_r),  int'(e_rpt[0]));
    chk("rep.pressed",   int'(prs_r),  int'(m_prs[0]));
    chk("norep.trig",    int'(trig_n), int'(e_trig[1]));
    chk("norep.trig_rpt",int'(rpt_n),  int'(e_rpt[1]));
    chk("norep.pressed", int'(prs_n),  int'(m_prs[1]));
    if (trig_r) begin
      rep_q.push_back(ecnt);
      rep_rq.push_back(int'(rpt_r));
    end
    if (trig_n) nor_q.push_back(ecnt);
    if (prev_prs_n && !prs_n) nor_fall.push_back(ecnt);
    prev_prs_n = prs_n;
  endtask

  task automatic cyc(input bit b);
    btn_in = b;
    @(posedge clk);
    ecnt++;
    if (n_rst) model_edge(b);
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic run_to(input bit b, input int target);
    while (ecnt < target) cyc(b);
  endtask

  int exp_rep[8]  = '{7, 27, 32, 37, 42, 72, 104, 118};
  int exp_rrq[8]  = '{0, 1, 1, 1, 1, 0, 1, 0};
  int exp_nor[3]  = '{7, 72, 118};

  initial begin
    total = 0; bad = 0; ecnt = 0; prev_prs_n = 1'b0;
    model_reset();
    n_rst  = 1'b1;
    btn_in = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    chk("reset.rep.trig",    int'(trig_r), 0);
    chk("reset.rep.rpt",     int'(rpt_r),  0);
    chk("reset.rep.pressed", int'(prs_r),  0);
    chk("reset.norep.trig",  int'(trig_n), 0);
    chk("reset.norep.pressed", int'(prs_n), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Long clean press then release; bounce burst; press with release bounce
    run_to(1'b1, 40);
    run_to(1'b0, 50);
    cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0);
    run_to(1'b0, 65);
    chk("bounce.idle.pressed", int'(prs_r), 0);
    run_to(1'b1, 79);
    run_to(1'b0, 81);
    run_to(1'b1, 108);
    chk("pre_reset.pressed", int'(prs_r), 1);

    // Reset one edge before the repeat due at edge 109
    #2 n_rst = 1'b0;
    model_reset();
    #1;
    chk("async_reset.rep.pressed",   int'(prs_r), 0);
    chk("async_reset.norep.pressed", int'(prs_n), 0);
    chk("async_reset.rep.trig",      int'(trig_r), 0);
    run_to(1'b1, 111);
    n_rst = 1'b1;
    run_to(1'b1, 122);
    run_to(1'b0, 135);

    chk("rep.pulse_count", rep_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < rep_q.size()) begin
        chk($sformatf("rep.pulse_edge%0d", i), rep_q[i], exp_rep[i]);
        chk($sformatf("rep.pulse_rpt%0d", i), rep_rq[i], exp_rrq[i]);
      end
    end
    chk("norep.pulse_count", nor_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < nor_q.size()) chk($sformatf("norep.pulse_edge%0d", i), nor_q[i], exp_nor[i]);
    end
    chk("norep.fall_seen", int'(nor_fall.size() > 0), 1);
    if (nor_fall.size() > 0) chk("norep.first_release_edge", nor_fall[0], 47);
    chk("final.pressed", int'(prs_r), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
